// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty flags, occupancy and sticky error flags.
// Latency: registered read data one cycle after rinc; `define SYNC_FIFO_FWFT_EN for first-word-fall-through.
// Backpressure: writes are dropped while wfull and reads while rempty, latching overflow/underflow.
module sync_fifo_prog #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int AFULL_TH  = 14,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
);

  localparam int             DEPTH    = 1 << ASIZE;
  localparam logic [ASIZE:0] DEPTH_L  = (ASIZE+1)'(DEPTH);
  localparam logic [ASIZE:0] AFULL_L  = (ASIZE+1)'(AFULL_TH);
  localparam logic [ASIZE:0] AEMPTY_L = (ASIZE+1)'(AEMPTY_TH);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             wr_acc;
  logic             rd_acc;

  // The extra pointer bit lets plain subtraction distinguish full from empty.
  assign level         = wptr - rptr;
  assign wfull         = (level == DEPTH_L);
  assign rempty        = (level == '0);
  assign walmost_full  = (level >= AFULL_L);
  assign ralmost_empty = (level <= AEMPTY_L);

  assign wr_acc = winc & ~wfull;
  assign rd_acc = rinc & ~rempty;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr[ASIZE-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // A fresh error in the same cycle outranks err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rinc && rempty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = mem[rptr[ASIZE-1:0]];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (rd_acc) begin
      rdata <= mem[rptr[ASIZE-1:0]];
    end
  end
`endif

endmodule
